// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN          : architectural word width
//   INST_NOP      : addi x0,x0,0, shown to decode when nothing is queued
//   RESET_PC_DEF  : default first fetch address
//   fetch_req_t   : fetch request payload (address)
//   fetch_rsp_t   : fetch response payload (instruction word)
//   fetch_entry_t : queue entry {pc, inst}
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
    } fetch_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
    } fetch_rsp_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue with a registered head entry.
//   clk, reset_n : clock, async active-low reset
//   push, din    : enqueue din
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all entries; head payload is held
//   head         : registered copy of the oldest entry
//   count        : number of entries held
//   full, empty  : occupancy flags
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH      = 2,
    parameter fetch_entry_t RESET_HEAD = '0,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     din,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             push_en;
    logic             pop_en;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign push_en   = push & ~flush;
    assign pop_en    = pop & ~empty & ~flush;
    assign rd_ptr_nx = rd_ptr + PTR_W'(1);

    // Storage array: contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= RESET_HEAD;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr_nx;
            end
            count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
            // New word becomes head when the queue is (or is about to be) empty.
            if (push_en && (empty || (pop_en && count == CNT_W'(1)))) begin
                head <= din;
            end else if (pop_en && count > CNT_W'(1)) begin
                head <= mem[rd_ptr_nx];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding RV32I decode.
//   clk, reset_n              : clock, async active-low reset
//   mem_req/addr/gnt          : instruction memory request channel
//   mem_rvalid/rdata          : in-order instruction memory responses
//   redirect_valid/pc         : flush and restart fetch at redirect_pc
//   inst_valid/ready, inst/pc : instruction handshake towards decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    localparam int unsigned  CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned  SUM_W      = CNT_W + 1;
    localparam fetch_entry_t RESET_HEAD = '{pc: word_align(RESET_PC), inst: INST_NOP};

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  pc_tag;
    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nx;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;
    fetch_entry_t     q_head;
    fetch_entry_t     q_din;
    fetch_req_t       req;
    logic             active;
    logic             take;
    logic             drop;
    logic             push;
    logic             pop;

    // Credit: in-flight plus queued words never exceed DEPTH, so a response
    // always finds room. Same-cycle returns/pops are deliberately ignored.
    assign mem_req = active && !redirect_valid &&
                     ((SUM_W'(outstanding) + SUM_W'(q_count)) < SUM_W'(DEPTH));
    assign req.addr = fetch_pc;
    assign mem_addr = req.addr;

    assign take            = mem_req & mem_gnt;
    assign drop            = mem_rvalid & (discard != '0);
    assign push            = mem_rvalid & ~drop & ~redirect_valid;
    assign pop             = inst_valid & inst_ready;
    assign outstanding_nx  = outstanding + CNT_W'(take) - CNT_W'(mem_rvalid);
    assign redirect_target = word_align(redirect_pc);
    assign q_din           = '{pc: pc_tag, inst: mem_rdata};

    assign inst_valid = ~q_empty;
    assign inst       = inst_valid ? q_head.inst : INST_NOP;
    assign pc         = q_head.pc;

    // Fetch/response bookkeeping; a redirect marks everything in flight stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active      <= 1'b0;
            fetch_pc    <= word_align(RESET_PC);
            pc_tag      <= word_align(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding_nx;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                pc_tag   <= redirect_target;
                discard  <= outstanding_nx;
            end else begin
                if (take) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (drop) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    pc_tag <= pc_tag + XLEN'(4);
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_HEAD (RESET_HEAD)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (q_din),
        .pop     (pop),
        .flush   (redirect_valid),
        .head    (q_head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    // The credit rule makes a push into a full queue impossible.
    assert property (@(posedge clk) disable iff (!reset_n) !(push && q_full));

endmodule
